// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_pkg
// ----------------------------------------------------------------------------
// Shared AHB-lite encodings (HTRANS, HSIZE, HBURST, HRESP), the same constants
// ahb_master uses, plus a byte-lane enable helper for lane-aligned accesses.
// No ports.
// Revision: 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Lane enables for a lane-aligned transfer. Sizes above a word are flagged
  // as errors elsewhere, so the value returned for them never reaches memory.
  function automatic logic [3:0] byte_enable(input logic [2:0] size,
                                             input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ============================================================================
// ahb_sram_array
// ----------------------------------------------------------------------------
// MEM_DEPTH x 32 word storage with byte-enable synchronous write and
// asynchronous read. Contents are deliberately not reset.
// Ports:
//   clk      - write clock
//   we_i     - write strobe
//   be_i     - 4-bit byte-lane enables
//   addr_i   - word index (shared by read and write)
//   wdata_i  - lane-aligned write data
//   rdata_o  - word at addr_i (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module ahb_sram_array #(
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) begin
          mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// ahb_sram_slave
// ----------------------------------------------------------------------------
// AHB-lite SRAM slave: address decode, alignment/range error check,
// programmable wait states and two-cycle ERROR response around a word array.
// Ports:
//   hclk, hresetn     - clock, asynchronous active-low reset
//   hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i,
//   hmastlock_i       - address-phase controls (hburst/hprot/hmastlock unused)
//   hwdata_i          - lane-aligned write data (data phase)
//   hready_i          - bus ready
//   hreadyout_o       - slave ready
//   hresp_o           - 00 OKAY / 01 ERROR
//   hrdata_o          - read data in the final OKAY read data-phase cycle
// Revision: 1.0 - initial release
// ============================================================================
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic                      hmastlock_i,
  input  logic [31:0]               hwdata_i,
  input  logic                      hready_i,
  output logic                      hreadyout_o,
  output logic [1:0]                hresp_o,
  output logic [31:0]               hrdata_o
);

  localparam int                        C_IDX_W = $clog2(MEM_DEPTH);
  localparam logic [AHB_ADDR_WIDTH-1:0] C_DEPTH = AHB_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0]                C_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [C_IDX_W-1:0] idx_q, idx_d;
  logic [3:0]         be_q, be_d;
  logic               write_q, write_d;
  // Set only for the final OKAY data-phase cycle of a real transfer.
  logic               active_q, active_d;
  logic               hreadyout_q, hreadyout_d;
  logic [1:0]         hresp_q, hresp_d;

  logic                      w_accept;
  logic                      w_err;
  logic [AHB_ADDR_WIDTH-1:0] w_word_addr;
  logic                      w_we;
  logic [31:0]               w_rdata;
  logic                      w_unused;

  assign w_accept    = hsel_i & hready_i & htrans_i[1];
  assign w_word_addr = haddr_i >> 2;

  // Range check on the full address so out-of-range words never alias.
  assign w_err = ((hsize_i == HSIZE_HALF) && haddr_i[0])
               | ((hsize_i == HSIZE_WORD) && (haddr_i[1:0] != 2'b00))
               | (hsize_i > HSIZE_WORD)
               | (w_word_addr >= C_DEPTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    be_d        = be_q;
    write_d     = write_q;
    active_d    = 1'b0;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    case (state_q)
      // ERR2 ends with hreadyout high, so it can accept the next address
      // phase exactly like IDLE.
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        if (w_accept) begin
          idx_d   = haddr_i[C_IDX_W+1:2];
          be_d    = byte_enable(hsize_i, haddr_i[1:0]);
          write_d = hwrite_i;
          if (w_err) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else if (WAIT_STATES > 0) begin
            state_d     = ST_WAIT;
            cnt_d       = C_WAIT;
            hreadyout_d = 1'b0;
          end else begin
            active_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // The cycle holding count 1 is the last low cycle.
        if (cnt_q <= 4'd1) begin
          state_d     = ST_IDLE;
          active_d    = 1'b1;
          hreadyout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      be_q        <= 4'd0;
      write_q     <= 1'b0;
      active_q    <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      write_q     <= write_d;
      active_q    <= active_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Commit at the edge ending the final OKAY cycle; hwdata_i is valid then.
  assign w_we = active_q & write_q;

  ahb_sram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (C_IDX_W)
  ) u_array (
    .clk     (hclk),
    .we_i    (w_we),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (hwdata_i),
    .rdata_o (w_rdata)
  );

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = (active_q & ~write_q) ? w_rdata : 32'h0;

  assign w_unused = ^{htrans_i[0], hburst_i, hprot_i, hmastlock_i};

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_ahb_sram_slave
// ----------------------------------------------------------------------------
// Directed bench for ahb_sram_slave. Two instances: dut0 with no wait states,
// dut2 with two. A pipelined master task drives a command list, pushes the
// expected response of each accepted address phase to a scoreboard and pops
// it when the data phase completes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          waits;
    string       tag;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hro0, hro2;
  logic [1:0]  hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int total = 0;
  int bad   = 0;

  cmd_t        cmds[$];
  exp_t        sb[$];
  logic [31:0] mdl [int];

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.AHB_ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel0), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
    .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(hro0),
    .hreadyout_o(hro0), .hresp_o(hresp0), .hrdata_o(hrdata0)
  );

  ahb_sram_slave #(.AHB_ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel2), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
    .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(hro2),
    .hreadyout_o(hro2), .hresp_o(hresp2), .hrdata_o(hrdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic w, input logic [2:0] s,
                     input logic [2:0] b, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.trans = t; c.write = w; c.size = s; c.burst = b; c.addr = a; c.wdata = d;
    cmds.push_back(c);
  endtask

  // Reference behaviour of one accepted address phase (independent of RTL).
  function automatic exp_t model(input cmd_t c, input int tgt);
    exp_t        e;
    int          key;
    logic [31:0] mask;
    logic [31:0] old;
    bit          err;
    e.resp  = HRESP_OKAY;
    e.data  = 32'h0;
    e.waits = 0;
    e.tag   = $sformatf("d%0d_%s_%s_%h", tgt, c.trans[1] ? (c.write ? "wr" : "rd") : "idl",
                        (c.size == 3'd0) ? "b" : (c.size == 3'd1) ? "h" : "w", c.addr);
    if (!c.trans[1]) return e;
    err = (c.size == 3'd1 && c.addr[0]) || (c.size == 3'd2 && c.addr[1:0] != 2'b00) ||
          (c.size > 3'd2) || ((c.addr >> 2) >= 32'd1024);
    if (err) begin
      e.resp  = HRESP_ERROR;
      e.waits = 1;
      return e;
    end
    e.waits = (tgt == 2) ? 2 : 0;
    key     = tgt * 65536 + int'(c.addr >> 2);
    if (c.write) begin
      case (c.size)
        3'd0:    mask = 32'hFF << (8 * c.addr[1:0]);
        3'd1:    mask = c.addr[1] ? 32'hFFFF0000 : 32'h0000FFFF;
        default: mask = 32'hFFFFFFFF;
      endcase
      old      = mdl.exists(key) ? mdl[key] : 32'h0;
      mdl[key] = (old & ~mask) | (c.wdata & mask);
    end else begin
      e.data = mdl[key];
    end
    return e;
  endfunction

  task automatic put_addr(input cmd_t c);
    htrans = c.trans; hwrite = c.write; hsize = c.size; hburst = c.burst; haddr = c.addr;
  endtask

  task automatic put_idle();
    htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
    haddr = 32'h0;
  endtask

  // Pipelined master: entered and left at posedge+1; samples at negedge.
  task automatic run(input int tgt, output int ncyc);
    cmd_t        dp;
    exp_t        e;
    bit          dp_valid = 0;
    bit          rdy;
    bit          resp_bad = 0;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          i = 0;
    int          waits = 0;
    int          guard = 0;
    ncyc  = 0;
    hsel0 = (tgt == 0);
    hsel2 = (tgt == 2);
    while ((i < cmds.size() || dp_valid) && guard < 200) begin
      if (i < cmds.size()) put_addr(cmds[i]); else put_idle();
      hwdata = dp_valid ? dp.wdata : 32'h0;
      @(negedge hclk);
      rdy   = (tgt == 0) ? hro0 : hro2;
      resp  = (tgt == 0) ? hresp0 : hresp2;
      rdata = (tgt == 0) ? hrdata0 : hrdata2;
      if (dp_valid) begin
        if (resp !== sb[0].resp) resp_bad = 1;
        if (!rdy) waits++;
        else begin
          e = sb.pop_front();
          chk({e.tag, "_waits"}, waits, e.waits);
          chk({e.tag, "_resp"}, {30'b0, resp}, {30'b0, e.resp});
          chk({e.tag, "_resp_stall"}, {31'b0, resp_bad}, 32'h0);
          chk({e.tag, "_rdata"}, rdata, e.data);
          waits    = 0;
          resp_bad = 0;
        end
      end
      @(posedge hclk);
      #1;
      ncyc++;
      guard++;
      if (rdy) begin
        dp_valid = 0;
        if (i < cmds.size()) begin
          dp       = cmds[i];
          dp_valid = 1;
          sb.push_back(model(dp, tgt));
          i++;
        end
      end
    end
    chk("run_completed", {31'b0, (i >= cmds.size() && !dp_valid)}, 32'h1);
    put_idle();
    hwdata = 32'h0;
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    cmds.delete();
  endtask

  initial begin
    int n;
    hresetn = 1'b0;
    hsel0   = 1'b0;
    hsel2   = 1'b0;
    hwdata  = 32'h0;
    put_idle();
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hready0", {31'b0, hro0}, 32'h1);
    chk("rst_hresp0", {30'b0, hresp0}, 32'h0);
    chk("rst_hrdata0", hrdata0, 32'h0);
    chk("rst_hready2", {31'b0, hro2}, 32'h1);
    chk("rst_hresp2", {30'b0, hresp2}, 32'h0);
    chk("rst_hrdata2", hrdata2, 32'h0);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Word write then pipelined read of the same word.
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h10, 32'hDEADBEEF);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h10, 32'h0);
    run(0, n);
    chk("t1_cycles", n, 3);

    // Byte and halfword lane writes.
    add(HTRANS_NONSEQ, 1, HSIZE_BYTE, HBURST_SINGLE, 32'h11, 32'h0000AA00);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h10, 32'h0);
    add(HTRANS_NONSEQ, 1, HSIZE_HALF, HBURST_SINGLE, 32'h12, 32'h12340000);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h10, 32'h0);
    run(0, n);
    chk("t2_model_word", mdl[32'h10 >> 2], 32'h1234AAEF);

    // Error responses; word 0 must stay untouched (0x1000 must not alias).
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h00, 32'h11111111);
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h02, 32'hFFFFFFFF);
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h1000, 32'h22222222);
    add(HTRANS_NONSEQ, 1, HSIZE_HALF, HBURST_SINGLE, 32'h01, 32'h33333333);
    add(HTRANS_NONSEQ, 0, 3'b011, HBURST_SINGLE, 32'h00, 32'h0);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h00, 32'h0);
    run(0, n);

    // INCR4 write then INCR4 read at one beat per cycle.
    for (int k = 0; k < 4; k++)
      add((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1, HSIZE_WORD, HBURST_INCR4,
          32'h20 + 32'(4 * k), 32'hA0000000 + 32'(k * 32'h01010101));
    run(0, n);
    for (int k = 0; k < 4; k++)
      add((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 0, HSIZE_WORD, HBURST_INCR4,
          32'h20 + 32'(4 * k), 32'h0);
    run(0, n);
    chk("t5_incr4_rd_cycles", n, 5);

    // Burst with BUSY/IDLE beats interleaved.
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_INCR, 32'h20, 32'h0);
    add(HTRANS_BUSY,   0, HSIZE_WORD, HBURST_INCR, 32'h24, 32'h0);
    add(HTRANS_SEQ,    0, HSIZE_WORD, HBURST_INCR, 32'h24, 32'h0);
    add(HTRANS_IDLE,   1, HSIZE_WORD, HBURST_SINGLE, 32'h28, 32'h55555555);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h28, 32'h0);
    run(0, n);

    // Two wait states, plus an error on the waited slave.
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h80, 32'hA5A55A5A);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h80, 32'h0);
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h83, 32'h0);
    add(HTRANS_NONSEQ, 1, HSIZE_WORD, HBURST_SINGLE, 32'h40, 32'hCAFEF00D);
    run(2, n);

    // Reset during the wait states of a write to 0x40.
    hsel2 = 1'b1;
    htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h40;
    @(posedge hclk);
    #1;
    put_idle();
    hwdata = 32'h0BADBEEF;
    @(negedge hclk);
    chk("t6_in_wait_hready", {31'b0, hro2}, 32'h0);
    hresetn = 1'b0;
    #1;
    chk("t6_rst_hready", {31'b0, hro2}, 32'h1);
    chk("t6_rst_hresp", {30'b0, hresp2}, 32'h0);
    chk("t6_rst_hrdata", hrdata2, 32'h0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    hsel2   = 1'b0;
    hwdata  = 32'h0;
    @(posedge hclk);
    #1;
    add(HTRANS_NONSEQ, 0, HSIZE_WORD, HBURST_SINGLE, 32'h40, 32'h0);
    run(2, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-lite slave holding a word-organised SRAM model with byte-lane writes, programmable wait states and two-cycle ERROR responses. It sits directly downstream of ahb_master and consumes its haddr/htrans/hwrite/hsize/hburst/hwdata. It returns hreadyout/hresp/hrdata on the lane-aligned 32-bit bus. The master performs lane shifting, so this slave always stores and returns full lane-aligned words.

Parameters:
AHB_ADDR_WIDTH, 32, width of haddr_i.
MEM_DEPTH, 1024, number of 32-bit words; must be a power of 2, at least 4.
WAIT_STATES, 0, hreadyout_o low cycles inserted before every OKAY data phase (0..15).

Ports:
hclk  input  1  AHB clock; all logic on rising edge.
hresetn  input  1  asynchronous active-low reset.
hsel_i  input  1  slave select.
haddr_i  input  AHB_ADDR_WIDTH  byte address.
htrans_i  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
hwrite_i  input  1  1 = write.
hsize_i  input  3  000 byte, 001 halfword, 010 word.
hburst_i  input  3  burst type; accepted, not used for addressing.
hprot_i  input  4  ignored.
hmastlock_i  input  1  ignored.
hwdata_i  input  32  lane-aligned write data, valid in data phase.
hready_i  input  1  bus ready; tie to hreadyout_o in single-slave systems.
hreadyout_o  output  1  slave ready.
hresp_o  output  2  00 OKAY, 01 ERROR.
hrdata_o  output  32  read data, valid when hreadyout_o=1 and hresp_o=OKAY in a read data phase.

Behaviour:
- Reset: hreadyout_o=1, hresp_o=00, hrdata_o=0, FSM=IDLE, pending-write flags cleared. Memory contents are not reset.
- Address phase accepted when hsel_i & hready_i & htrans_i[1]. Register word index, byte enables, hwrite and the error flag.
- Byte enables: byte gives 1 lane at haddr[1:0]; halfword gives lanes {1:0} or {3:2} by haddr[1]; word gives all 4.
- Error flag is set when any of these holds:
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=0;
  - hsize_i > 010;
  - word index (haddr>>2) >= MEM_DEPTH.
- IDLE/BUSY transfers, and cycles with hsel_i=0, get a zero-wait OKAY. FSM stays IDLE.
- FSM states IDLE, WAIT, ERR1, ERR2. All transitions are evaluated at the edge that ends the address phase or the current data-phase cycle.
  - IDLE: on accepted transfer, go to ERR1 if error. Otherwise go to WAIT if WAIT_STATES>0, else complete in the next cycle (stay IDLE with the data phase active).
  - WAIT: hreadyout_o=0, hresp_o=00. Counter loads WAIT_STATES and decrements. When it reaches 0, the next cycle is the final data-phase cycle with hreadyout_o=1.
  - ERR1: hreadyout_o=0, hresp_o=01, always followed by ERR2.
  - ERR2: hreadyout_o=1, hresp_o=01. A new accepted address phase in this cycle is honoured, otherwise return to IDLE.
- Write commits at the rising edge ending the final OKAY data-phase cycle.
  - Only enabled lanes of hwdata_i are written.
  - Erroring writes never modify memory.
- Read: hrdata_o = mem[index] combinationally in the final OKAY data-phase cycle, otherwise 0.
  - Because the write commits at the edge before a pipelined following read's data phase, back-to-back write-then-read of the same word returns the new data.
- Pipelining: a new address phase overlapping the final data-phase cycle of the previous transfer is accepted, giving back-to-back NONSEQ/SEQ with WAIT_STATES=0 at one beat per cycle.
- An address phase presented while hready_i=0 is not accepted; the master must hold it.
- Reset mid-transfer: the pending write is discarded, the FSM returns to IDLE and outputs take reset values.
- Word index uses haddr[$clog2(MEM_DEPTH)+1:2]. The range check uses the full address, so addresses are not aliased.

Decomposition:
- Shared package ahb_pkg holds the HTRANS, HSIZE, HBURST and HRESP encodings (the same constants ahb_master uses).
- Sub-module ahb_sram_array holds the MEM_DEPTH x 32 register array, with 4-bit byte-enable synchronous write and asynchronous read.
- ahb_sram_slave contains address decode, error check, wait counter and FSM.

Test Plan:
1. WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then pipelined word read of 0x10 -> OKAY with zero wait states; hrdata_o=0xDEADBEEF in the read data phase.
2. Byte write 0x0000AA00 to 0x11, then word read of 0x10 -> 0xDEADAAEF; halfword write 0x12340000 to 0x12, then read -> 0x1234AAEF.
3. WAIT_STATES=2: word read -> hreadyout_o low for exactly 2 cycles, high with data on the 3rd data-phase cycle.
4. Word access at 0x02, and at 0x1000 with MEM_DEPTH=1024 -> ERR1 (hreadyout 0, hresp 01) then ERR2 (hreadyout 1, hresp 01); memory unchanged.
5. INCR4 write 0x20..0x2C (NONSEQ + 3 SEQ), then INCR4 read -> 4 OKAY beats in 4 cycles; read data matches; IDLE/BUSY beats interleaved give OKAY with no memory access.
6. Assert hresetn low during the WAIT of a write to 0x40 -> outputs return to reset values; later read of 0x40 shows the old value.
